// File: rtl/cdc_xfer_sched.sv
// cdc_xfer_sched
// Source-domain scheduler sharing one multi-bit CDC channel between NUM_REQ
// requesters. A granted word is driven on unsync_bus with bus_enable high for
// HOLD_CYCLES, then bus_enable low for GAP_CYCLES. The destination-side data
// synchronizer therefore sees exactly one enable rising edge per word.
//
// Ports:
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   req        : level request per requester
//   req_data   : packed words, requester i at [i*BUS_WIDTH +: BUS_WIDTH]
//   ack        : one-cycle pulse, the requester's word has been captured
//   busy       : high while a transfer is in HOLD or GAP
//   grant_id   : index of the last granted requester
//   unsync_bus : registered word to the synchronizer
//   bus_enable : registered enable level to the synchronizer
//
// Optional build macro FIXED_PRIO_EN: lowest requester index always wins and
// the round-robin pointer is removed. Default build is round-robin.
module cdc_xfer_sched #(
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_REQ     = 4,
    parameter int ID_WIDTH    = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          busy,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic [BUS_WIDTH-1:0]          unsync_bus,
    output logic                          bus_enable
);

    localparam int IW1 = ID_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  found;
    logic [ID_WIDTH-1:0]   winner;
    logic [IW1-1:0]        idx;
    logic [NUM_REQ-1:0]    req_sh;
    logic [BUS_WIDTH-1:0]  win_word;

`ifndef FIXED_PRIO_EN
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

    // Requester index holding top priority for the next arbitration.
    logic [ID_WIDTH-1:0]   ptr;
`endif

    // Winner search: first requester with req high, scanning upward from the
    // priority pointer with wrap-around (or from index 0 in fixed priority).
    // idx carries one extra bit so the wrap works for non-power-of-2 NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        req_sh = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef FIXED_PRIO_EN
            idx = IW1'(k);
`else
            idx = {1'b0, ptr} + IW1'(k);
            if (idx >= IW1'(NUM_REQ)) begin
                idx = idx - IW1'(NUM_REQ);
            end
`endif
            req_sh = req >> idx;
            if (!found && req_sh[0]) begin
                found  = 1'b1;
                winner = idx[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        win_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_WIDTH'(i)) begin
                win_word = req_data[i*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    // cnt holds the remaining cycles of the current phase minus one, so a
    // phase ends on the edge where cnt is already zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            unsync_bus <= '0;
            bus_enable <= 1'b0;
            ack        <= '0;
            busy       <= 1'b0;
            grant_id   <= '0;
`ifndef FIXED_PRIO_EN
            ptr        <= '0;
`endif
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state      <= HOLD;
                        cnt        <= CNT_WIDTH'(HOLD_CYCLES - 1);
                        unsync_bus <= win_word;
                        bus_enable <= 1'b1;
                        busy       <= 1'b1;
                        grant_id   <= winner;
                        ack        <= NUM_REQ'(1) << winner;
`ifndef FIXED_PRIO_EN
                        ptr        <= (winner == LAST_ID) ? '0 : winner + 1'b1;
`endif
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state      <= GAP;
                        cnt        <= CNT_WIDTH'(GAP_CYCLES - 1);
                        bus_enable <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_xfer_sched.sv
// tb_cdc_xfer_sched
// Self-checking bench for cdc_xfer_sched (NUM_REQ=4, BUS_WIDTH=8, HOLD=4,
// GAP=4). A transfer-level reference model tracks the cycle of the last grant,
// the captured word and the next priority index; expected outputs are derived
// from the elapsed cycles since that grant.
module tb_cdc_xfer_sched;

    localparam int BW = 8;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int H  = 4;
    localparam int G  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*BW-1:0]   req_data;
    logic [N-1:0]      ack;
    logic              busy;
    logic [IW-1:0]     grant_id;
    logic [BW-1:0]     unsync_bus;
    logic              bus_enable;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    // reference model state
    bit        m_active = 1'b0;
    int        m_g      = 0;
    int        m_word   = 0;
    int        m_id     = 0;
    int        m_ptr    = 0;
    int        m_ack    = 0;

    cdc_xfer_sched #(
        .BUS_WIDTH  (BW),
        .NUM_REQ    (N),
        .ID_WIDTH   (IW),
        .HOLD_CYCLES(H),
        .GAP_CYCLES (G),
        .CNT_WIDTH  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .busy      (busy),
        .grant_id  (grant_id),
        .unsync_bus(unsync_bus),
        .bus_enable(bus_enable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Model update for the edge just taken, using the inputs present at it.
    task automatic model_edge();
        int  w;
        int  i;
        bit  fnd;
        logic [N-1:0]    rs;
        logic [N*BW-1:0] ds;
        cyc++;
        if (rst) begin
            m_active = 1'b0;
            m_word   = 0;
            m_id     = 0;
            m_ptr    = 0;
            m_ack    = 0;
        end else begin
            m_ack = 0;
            if ((!m_active || (cyc - m_g) >= H + G + 1) && req != '0) begin
                fnd = 1'b0;
                w   = 0;
                for (int k = 0; k < N; k++) begin
`ifdef FIXED_PRIO_EN
                    i = k;
`else
                    i = (m_ptr + k) % N;
`endif
                    rs = req >> i;
                    if (!fnd && rs[0]) begin
                        fnd = 1'b1;
                        w   = i;
                    end
                end
                ds       = req_data >> (w * BW);
                m_word   = int'(ds[BW-1:0]);
                m_id     = w;
                m_ptr    = (w + 1) % N;
                m_g      = cyc;
                m_active = 1'b1;
                m_ack    = 1 << w;
            end
        end
    endtask

    task automatic check_outputs();
        int  el;
        bit  e_be;
        bit  e_busy;
        el     = cyc - m_g;
        e_be   = m_active && (el < H);
        e_busy = m_active && (el < H + G);
        chk("bus_enable", 32'(bus_enable), 32'(e_be));
        chk("busy",       32'(busy),       32'(e_busy));
        chk("ack",        32'(ack),        32'(m_ack));
        chk("grant_id",   32'(grant_id),   32'(m_id));
        chk("unsync_bus", 32'(unsync_bus), 32'(m_word));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step(input int n);
        for (int s = 0; s < n; s++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
        end
    endtask

    initial begin
        rst      = 1'b1;
        req      = 4'hF;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        @(negedge clk);

        // reset held with all requests pending: everything stays zero
        step(2);
        chk("reset_ack_zero", 32'(ack), 32'd0);

        // round-robin with all requests held: 11,22,33,44,11,...
        rst = 1'b0;
        step(1);
        chk("first_grant_req0", 32'(grant_id), 32'd0);
        step(44);

        // drain to idle
        req = '0;
        step(12);

        // single request from requester 2
        req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        req      = 4'b0100;
        step(1);
        chk("single_word", 32'(unsync_bus), 32'hA5);
        req = '0;
        step(12);

        // data stability: change data and drop req in the middle of HOLD
        req_data = {8'h00, 8'h00, 8'h00, 8'h5A};
        req      = 4'b0001;
        step(2);
        req_data = 32'(($urandom()));
        req      = '0;
        step(12);
        chk("stable_word", 32'(unsync_bus), 32'h5A);

        // reset on the second HOLD cycle, pointer returns to requester 0
        req      = 4'b0110;
        req_data = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        step(2);
        req = 4'hF;
        rst = 1'b1;
        step(1);
        chk("rst_mid_hold_be", 32'(bus_enable), 32'd0);
        rst = 1'b0;
        step(1);
        chk("post_rst_grant", 32'(grant_id), 32'd0);
        step(10);

        // randomized traffic with occasional resets
        for (int r = 0; r < 400; r++) begin
            req      = N'($urandom());
            req_data = 32'($urandom());
            rst      = ($urandom_range(0, 79) == 0);
            step(1);
        end
        rst = 1'b0;
        req = '0;
        step(12);

`ifdef FIXED_PRIO_EN
        // requester 1 always beats requester 3
        req = 4'b1010;
        for (int r = 0; r < 5; r++) begin
            step(1);
            chk("fixed_prio_id", 32'(grant_id), 32'd1);
            step(8);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
